sync_fifo: RTL

Single-clock, parametrised FIFO. It is the same-clock-domain successor of the team's dual-clock FIFO and keeps the same data/flag port family. It adds four things: a selectable first-word-fall-through read mode, run-time programmable almost-full/almost-empty thresholds, an occupancy output, and sticky overflow/underflow error flags with a synchronous flush. It sits between producer and consumer logic running on one clock.

---
 rtl/sync_fifo.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with optional first-word-fall-through output, programmable
// almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module sync_fifo #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 4,
  parameter int FWFT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  input  logic [ASIZE:0]   afull_th,
  input  logic [ASIZE:0]   aempty_th,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_W = (ASIZE+1)'(DEPTH);

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic [ASIZE:0]   level_q;
  logic [DSIZE-1:0] rdata_q;
  logic             valid_q;
  logic             wfull_q;
  logic             awfull_q;
  logic             rempty_q;
  logic             arempty_q;
  logic             ovf_q;
  logic             udf_q;

  logic             wr_acc;
  logic             rd_acc;
  logic             mem_rd;
  logic             mem_nonempty;
  logic             valid_nxt;
  logic [ASIZE:0]   level_nxt;

  // In FWFT mode the prefetch register is the visible head; its valid bit is the empty flag.
  assign rempty       = (FWFT != 0) ? !valid_q : rempty_q;
  assign mem_nonempty = (wptr != rptr);

  always_comb begin
    wr_acc    = winc && !wfull_q && !flush;
    rd_acc    = rinc && !rempty && !flush;
    mem_rd    = 1'b0;
    valid_nxt = 1'b0;
    if (FWFT != 0) begin
      mem_rd    = !flush && mem_nonempty && (!valid_q || rd_acc);
      valid_nxt = flush ? 1'b0 : (mem_rd ? 1'b1 : (rd_acc ? 1'b0 : valid_q));
    end else begin
      mem_rd    = rd_acc;
    end
    if (flush)
      level_nxt = '0;
    else
      level_nxt = level_q + {{ASIZE{1'b0}}, wr_acc} - {{ASIZE{1'b0}}, rd_acc};
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wptr[ASIZE-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      valid_q <= valid_nxt;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_acc)
          wptr <= wptr + 1'b1;
        if (mem_rd) begin
          rptr    <= rptr + 1'b1;
          rdata_q <= mem[rptr[ASIZE-1:0]];
        end
      end
    end
  end

  // Flags are computed from the post-edge occupancy so they never depend on winc/rinc combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= '0;
      wfull_q   <= 1'b0;
      awfull_q  <= 1'b0;
      rempty_q  <= 1'b1;
      arempty_q <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      level_q   <= level_nxt;
      wfull_q   <= (level_nxt == DEPTH_W);
      awfull_q  <= (afull_th != '0) && (level_nxt >= afull_th);
      rempty_q  <= (level_nxt == '0);
      arempty_q <= (level_nxt <= aempty_th);
      if (flush) begin
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end else begin
        if (winc && wfull_q)
          ovf_q <= 1'b1;
        if (rinc && rempty)
          udf_q <= 1'b1;
      end
    end
  end

  assign rdata     = rdata_q;
  assign level     = level_q;
  assign wfull     = wfull_q;
  assign awfull    = awfull_q;
  assign arempty   = arempty_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule
